// File: rtl/touch_adc_pkg.sv
// +----------------------------------------------------------------------------+
// | touch_adc_pkg                                                              |
// | Shared encodings and widths for the ADS7843-style touch-ADC responder.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package touch_adc_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_CMD  = 3'd1;
    localparam state_t ST_BUSY = 3'd2;
    localparam state_t ST_DATA = 3'd3;
    localparam state_t ST_TAIL = 3'd4;

    localparam int CMD_S_BIT    = 7;
    localparam int CMD_A_HI     = 6;
    localparam int CMD_A_LO     = 4;
    localparam int CMD_MODE_BIT = 3;
    localparam int CMD_SER_BIT  = 2;
    localparam int CMD_PD_HI    = 1;
    localparam int CMD_PD_LO    = 0;

    localparam logic [3:0] CMD_BITS = 4'd8;

    localparam logic [2:0] DEF_CH_X = 3'b101;
    localparam logic [2:0] DEF_CH_Y = 3'b001;

    localparam int DATA_W  = 12;
    localparam int DATA_W8 = 8;

    // 8-bit mode left-justifies the top byte so the MSB always leaves first.
    function automatic logic [DATA_W-1:0] align_value(input logic [DATA_W-1:0] value,
                                                      input logic mode8);
        return mode8 ? {value[DATA_W-1:DATA_W-DATA_W8], {(DATA_W-DATA_W8){1'b0}}} : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/touch_adc_responder_if.sv
// +----------------------------------------------------------------------------+
// | touch_adc_responder_if                                                     |
// | Serial touch-ADC link plus coordinate-load side channel.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface touch_adc_responder_if;
    import touch_adc_pkg::*;

    logic              adc_din;
    logic              adc_dclk;
    logic              adc_cs;
    logic              adc_dout;
    logic              adc_busy;
    logic              adc_penirq_n;
    logic [DATA_W-1:0] x_coord;
    logic [DATA_W-1:0] y_coord;
    logic              new_coord;
    logic              cmd_err;

    modport slave (
        input  adc_din, adc_dclk, adc_cs, x_coord, y_coord, new_coord,
        output adc_dout, adc_busy, adc_penirq_n, cmd_err
    );

    modport master (
        output adc_din, adc_dclk, adc_cs, x_coord, y_coord, new_coord,
        input  adc_dout, adc_busy, adc_penirq_n, cmd_err
    );

endinterface

`default_nettype wire

// File: rtl/sync_edge_det.sv
// +----------------------------------------------------------------------------+
// | sync_edge_det                                                              |
// | Multi-stage synchronizer with registered-level rise/fall pulse outputs.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic sig,
    output logic      level,
    output logic      rise,
    output logic      fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_edge <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig};
            r_edge <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  = level & ~r_edge;
    assign fall  = ~level & r_edge;

endmodule

`default_nettype wire

// File: rtl/touch_adc_responder.sv
// +----------------------------------------------------------------------------+
// | touch_adc_responder                                                        |
// | Converter side of the serial touch-ADC link: decodes commands, returns X/Y.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module touch_adc_responder
    import touch_adc_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] CH_X        = DEF_CH_X,
    parameter logic [2:0] CH_Y        = DEF_CH_Y
) (
    input  wire logic             clk,
    input  wire logic             rst,
    touch_adc_responder_if.slave  adc
);

    logic w_din_lvl, w_din_rise_unused, w_din_fall_unused;
    logic w_dclk_lvl_unused, w_dclk_rise, w_dclk_fall;
    logic w_cs_lvl, w_cs_rise_unused, w_cs_fall_unused;
    logic w_nc_lvl_unused, w_nc_rise_unused, w_nc_fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
        .clk(clk), .rst(rst), .sig(adc.adc_din),
        .level(w_din_lvl), .rise(w_din_rise_unused), .fall(w_din_fall_unused));
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dclk (
        .clk(clk), .rst(rst), .sig(adc.adc_dclk),
        .level(w_dclk_lvl_unused), .rise(w_dclk_rise), .fall(w_dclk_fall));
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .sig(adc.adc_cs),
        .level(w_cs_lvl), .rise(w_cs_rise_unused), .fall(w_cs_fall_unused));
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nc (
        .clk(clk), .rst(rst), .sig(adc.new_coord),
        .level(w_nc_lvl_unused), .rise(w_nc_rise_unused), .fall(w_nc_fall));

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic [5:0]        r_cmd_sr, w_cmd_sr_nxt;
    logic [2:0]        r_chan, w_chan_nxt;
    logic              r_mode, w_mode_nxt;
    logic [3:0]        r_cfg_unused, w_cfg_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic              r_dout, w_dout_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_cmd_err, w_cmd_err_nxt;
    logic [DATA_W-1:0] r_x, w_x_nxt, r_y, w_y_nxt;
    logic              r_pen_down, w_pen_down_nxt;
    logic              r_x_done, w_x_done_nxt, r_y_done, w_y_done_nxt;
    logic              r_penirq_n;

    logic [7:0]        w_cmd_word;
    logic [2:0]        w_cmd_chan;
    logic [DATA_W-1:0] w_sel_val;
    logic [3:0]        w_width;

    assign w_cmd_word = {1'b1, r_cmd_sr, w_din_lvl};
    assign w_cmd_chan = w_cmd_word[CMD_A_HI:CMD_A_LO];
    assign w_sel_val  = (w_cmd_chan == CH_X) ? r_x :
                        (w_cmd_chan == CH_Y) ? r_y : '0;
    assign w_width    = r_mode ? 4'(DATA_W8) : 4'(DATA_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // CS high overrides any DCLK edge seen in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_lvl) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_CMD;
                ST_CMD:  if (w_dclk_fall && r_bit_cnt == CMD_BITS) w_state_nxt = ST_BUSY;
                ST_BUSY: if (w_dclk_fall) w_state_nxt = ST_DATA;
                ST_DATA: if (w_dclk_fall && r_bit_cnt == w_width) w_state_nxt = ST_TAIL;
                ST_TAIL: if (w_dclk_rise && w_din_lvl) w_state_nxt = ST_CMD;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_bit_cnt_nxt = r_bit_cnt;
        w_cmd_sr_nxt  = r_cmd_sr;
        w_chan_nxt    = r_chan;
        w_mode_nxt    = r_mode;
        w_cfg_nxt     = r_cfg_unused;
        w_shift_nxt   = r_shift;
        w_dout_nxt    = r_dout;
        w_busy_nxt    = r_busy;
        w_cmd_err_nxt = 1'b0;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_x_done_nxt  = r_x_done;
        w_y_done_nxt  = r_y_done;

        if (w_cs_lvl) begin
            w_dout_nxt    = 1'b0;
            w_busy_nxt    = 1'b0;
            w_bit_cnt_nxt = '0;
            w_cmd_err_nxt = (r_state == ST_CMD && r_bit_cnt != '0) ||
                            (r_state == ST_BUSY) || (r_state == ST_DATA);
        end else begin
            case (r_state)
                ST_IDLE: w_bit_cnt_nxt = '0;
                ST_CMD: begin
                    if (w_dclk_rise && r_bit_cnt != CMD_BITS) begin
                        if (r_bit_cnt == '0) begin
                            if (w_din_lvl) w_bit_cnt_nxt = 4'd1;
                        end else begin
                            w_cmd_sr_nxt  = {r_cmd_sr[4:0], w_din_lvl};
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                            if (r_bit_cnt == CMD_BITS - 4'd1) begin
                                w_chan_nxt  = w_cmd_chan;
                                w_mode_nxt  = w_cmd_word[CMD_MODE_BIT];
                                w_cfg_nxt   = {w_cmd_word[CMD_S_BIT], w_cmd_word[CMD_SER_BIT],
                                               w_cmd_word[CMD_PD_HI:CMD_PD_LO]};
                                w_shift_nxt = align_value(w_sel_val, w_cmd_word[CMD_MODE_BIT]);
                            end
                        end
                    end else if (w_dclk_fall && r_bit_cnt == CMD_BITS) begin
                        w_busy_nxt = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_dclk_fall) begin
                        w_busy_nxt    = 1'b0;
                        w_dout_nxt    = r_shift[DATA_W-1];
                        w_shift_nxt   = {r_shift[DATA_W-2:0], 1'b0};
                        w_bit_cnt_nxt = 4'd1;
                    end
                end
                ST_DATA: begin
                    if (w_dclk_fall) begin
                        if (r_bit_cnt == w_width) begin
                            w_dout_nxt = 1'b0;
                            if (r_chan == CH_X) w_x_done_nxt = 1'b1;
                            if (r_chan == CH_Y) w_y_done_nxt = 1'b1;
                        end else begin
                            w_dout_nxt    = r_shift[DATA_W-1];
                            w_shift_nxt   = {r_shift[DATA_W-2:0], 1'b0};
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_TAIL: begin
                    w_dout_nxt = 1'b0;
                    if (w_dclk_rise && w_din_lvl) w_bit_cnt_nxt = 4'd1;
                end
                default: w_bit_cnt_nxt = '0;
            endcase
        end

        // A new pair re-arms the pen flag even if a read completes this cycle.
        if (w_nc_fall) begin
            w_x_nxt      = adc.x_coord;
            w_y_nxt      = adc.y_coord;
            w_x_done_nxt = 1'b0;
            w_y_done_nxt = 1'b0;
        end
        w_pen_down_nxt = w_nc_fall ? 1'b1 :
                         (w_x_done_nxt && w_y_done_nxt) ? 1'b0 : r_pen_down;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt    <= '0;
            r_cmd_sr     <= '0;
            r_chan       <= '0;
            r_mode       <= 1'b0;
            r_cfg_unused <= '0;
            r_shift      <= '0;
            r_dout       <= 1'b0;
            r_busy       <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_pen_down   <= 1'b0;
            r_x_done     <= 1'b0;
            r_y_done     <= 1'b0;
            r_penirq_n   <= 1'b1;
        end else begin
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_cmd_sr     <= w_cmd_sr_nxt;
            r_chan       <= w_chan_nxt;
            r_mode       <= w_mode_nxt;
            r_cfg_unused <= w_cfg_nxt;
            r_shift      <= w_shift_nxt;
            r_dout       <= w_dout_nxt;
            r_busy       <= w_busy_nxt;
            r_cmd_err    <= w_cmd_err_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_pen_down   <= w_pen_down_nxt;
            r_x_done     <= w_x_done_nxt;
            r_y_done     <= w_y_done_nxt;
            r_penirq_n   <= ~w_pen_down_nxt;
        end
    end

    assign adc.adc_dout     = r_dout;
    assign adc.adc_busy     = r_busy;
    assign adc.adc_penirq_n = r_penirq_n;
    assign adc.cmd_err      = r_cmd_err;

endmodule

`default_nettype wire
